mmio_display_ctrl: RTL and testbench
====================================

// Module: mmio_display_ctrl
// PURPOSE
//  Memory-mapped I/O peripheral on the processor data bus (memwrite/dataadr/writedata), next to dmem.
//  Decodes a 16-byte window at BASE_ADDR: store-driven 4-digit hex 7-seg display; debounced SW[4:0] status.
//  Provides rdata plus a hit flag; top-level read mux selects rdata over dmem readdata when hit=1.
// PARAMETERS
//  BASE_ADDR        32'hFFFF_FF00  word-aligned base of 16-byte register window (bits[3:0] must be 0)
//  DEBOUNCE_CYCLES  50000          cycles synced SW must differ from stable value before it is accepted (>=2)
//  BLINK_HALF       12500000       cycles per blink half-period (>=1; used only with MMIO_BLINK_EN)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  memwrite   in   1   store strobe from processor
//  dataadr    in   32  byte address from processor ALU
//  writedata  in   32  store data
//  hit        out  1   dataadr[31:4]==BASE_ADDR[31:4] (combinational)
//  rdata      out  32  read data for addressed register (combinational, 0 when hit=0)
//  SW         in   5   raw board switches (asynchronous)
//  gled,gled2,gled3,gled4 out 7 digit0..3 segments {g,f,e,d,c,b,a}, active-low; gled = least-significant nibble
// BEHAVIOUR
//  Register map (offset = dataadr[3:2]; dataadr[1:0] ignored):
//   0x0 DISP   R/W  [15:0] four hex nibbles; [31:16] read 0, writes ignored
//   0x4 CTRL   R/W  [0] EN (1=display on), [1] BLINK; [31:2] read 0
//   0x8 SWST   RO   [4:0] debounced switch state; writes ignored
//   0xC SWCHG  W1C  [4:0] sticky per-bit change flags; write 1 clears bit
//  Writes: memwrite&hit at a rising edge updates register; new value visible on rdata and segments next cycle.
//  Reset: DISP=0, CTRL=0, SWCHG=0, SWST=0, sync FFs=0, debounce counter=0, blink phase=0;
//   all gled* = 7'h7F (blank) since EN=0. Reset mid-operation discards any pending debounce.
//  Switch path: 2-FF synchroniser per bit -> shared debounce counter:
//   sync==SWST: counter<=0; sync!=SWST: counter++; at counter==DEBOUNCE_CYCLES-1: SWST<=sync, counter<=0,
//   SWCHG |= (sync^SWST). Sync vector changing again mid-count does not restart count (shared compare only).
//   Accept latency from stable raw input: 2 sync cycles + DEBOUNCE_CYCLES cycles.
//  SWCHG same-cycle conflict: hardware set wins over W1C clear for that bit.
//  Segment decode: standard hex 0-F (0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E active-low);
//   EN=0 -> all digits 7'h7F; outputs registered (one cycle after DISP/CTRL change).
//  Counter widths: $clog2 of parameter, no wrap beyond terminal value.
// CONFIGURATION
//  `MMIO_BLINK_EN defined: free-running blink counter toggles phase every BLINK_HALF cycles;
//   EN=1 & BLINK=1 & phase=1 -> all digits 7'h7F; counter runs regardless of BLINK; reset phase=0.
//  Not defined: no blink counter; CTRL[1] not stored, reads 0; display steady whenever EN=1.
// TESTING (bench: DEBOUNCE_CYCLES=4, BLINK_HALF=3)
//  Reset asserted mid-run -> gled..gled4=7'h7F, rdata at 0x0/0x4/0x8/0xC all 0, immediately (async).
//  Store 0x0000_12AF @0x0, 0x1 @0x4 -> next cycle gled=7'h0E, gled2=7'h08, gled3=7'h24, gled4=7'h79.
//  SW 0->5'h05 held -> SWST=5'h05 exactly 6 cycles later, SWCHG=5'h05; 2-cycle glitch -> SWST unchanged.
//  W1C 0x1 to 0xC same cycle as new SW[2] acceptance -> SWCHG=5'h04 (bit0 cleared, bit2 set wins).
//  Store @0xFFFF_FEFC (outside window) -> hit=0, rdata=0, no register change.
//  With `MMIO_BLINK_EN, CTRL=0x3 -> digits alternate shown/7'h7F every 3 cycles; without it CTRL reads 0x1.

Source files
------------

// File: rtl/mmio_display_ctrl.sv
// mmio_display_ctrl: memory-mapped peripheral on the processor data bus.
// Implements a 16-byte register window at BASE_ADDR with four registers:
//   0x0 DISP  : four hex digits shown on the active-low 7-segment outputs
//   0x4 CTRL  : display enable (and blink when built with MMIO_BLINK_EN)
//   0x8 SWST  : debounced switch state (read only)
//   0xC SWCHG : sticky switch-change flags (write 1 to clear)
// Optional feature: define MMIO_BLINK_EN to add a free-running blink phase
// that blanks the display every other BLINK_HALF cycles while CTRL[1] is set.
module mmio_display_ctrl #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          BLINK_HALF      = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        hit,
    output logic [31:0] rdata,
    input  logic [4:0]  SW,
    output logic [6:0]  gled,
    output logic [6:0]  gled2,
    output logic [6:0]  gled3,
    output logic [6:0]  gled4
);

    localparam int            DW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]    BLANK   = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic [1:0] offset;
    logic       wr_en;

    assign offset = dataadr[3:2];
    assign hit    = (dataadr[31:4] == BASE_ADDR[31:4]);
    assign wr_en  = memwrite & hit;

    // Byte lanes and the upper store half have no destination in this block.
    logic unused_bits;
    assign unused_bits = ^{writedata[31:16], dataadr[1:0]};

    // ---------------------------------------------------------------
    // Processor-visible registers
    // ---------------------------------------------------------------
    logic [15:0] disp;
    logic        en;
    logic        blink;
    logic        phase;

    // DISP and CTRL.EN are updated by stores into their slots.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (reset) begin
            disp <= '0;
            en   <= 1'b0;
        end else if (wr_en) begin
            case (offset)
                2'd0:    disp <= writedata[15:0];
                2'd1:    en   <= writedata[0];
                default: ;
            endcase
        end
    end

`ifdef MMIO_BLINK_EN
    localparam int            BW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt;

    // CTRL.BLINK storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blink <= 1'b0;
        else if (wr_en && offset == 2'd1)
            blink <= writedata[1];
    end

    // Free-running half-period counter; flips the blink phase at each terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    localparam int unused_blink_half = BLINK_HALF;
    assign blink = 1'b0;
    assign phase = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Switch synchroniser and shared debounce
    // ---------------------------------------------------------------
    logic [4:0]    sw_sync1;
    logic [4:0]    sw_sync2;
    logic [4:0]    swst;
    logic [4:0]    swchg;
    logic [DW-1:0] db_cnt;
    logic          accept;
    logic [4:0]    chg_set;
    logic [4:0]    chg_clr;

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= SW;
            sw_sync2 <= sw_sync1;
        end
    end

    // A difference held long enough is accepted; any flag it raises beats a same-cycle clear.
    assign accept  = (sw_sync2 != swst) && (db_cnt == DB_LAST);
    assign chg_set = accept ? (sw_sync2 ^ swst) : 5'd0;
    assign chg_clr = (wr_en && offset == 2'd3) ? writedata[4:0] : 5'd0;

    // Shared counter: runs while the synced vector differs from SWST, clears as soon as it matches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swst   <= '0;
            swchg  <= '0;
            db_cnt <= '0;
        end else begin
            if (sw_sync2 == swst) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                swst   <= sw_sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            swchg <= (swchg & ~chg_clr) | chg_set;
        end
    end

    // ---------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------
    // Returns the addressed register, zero outside the window.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        rdata = '0;
        if (hit) begin
            case (offset)
                2'd0: rdata[15:0] = disp;
                2'd1: rdata[1:0]  = {blink, en};
                2'd2: rdata[4:0]  = swst;
                2'd3: rdata[4:0]  = swchg;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Segment outputs
    // ---------------------------------------------------------------
    logic show;
    assign show = en & ~(blink & phase);

    // Registered digit drivers, blanked when disabled or in the dark blink phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gled  <= BLANK;
            gled2 <= BLANK;
            gled3 <= BLANK;
            gled4 <= BLANK;
        end else begin
            gled  <= show ? hex_to_seg(disp[3:0])   : BLANK;
            gled2 <= show ? hex_to_seg(disp[7:4])   : BLANK;
            gled3 <= show ? hex_to_seg(disp[11:8])  : BLANK;
            gled4 <= show ? hex_to_seg(disp[15:12]) : BLANK;
        end
    end

endmodule

// File: tb/tb_mmio_display_ctrl.sv
// tb_mmio_display_ctrl: randomized, scoreboard-checked bench for mmio_display_ctrl.
// The driver pushes expected values into a queue; a negedge monitor pops and compares.
// Build with MMIO_BLINK_EN defined to exercise the blink option.
module tb_mmio_display_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int          DEB  = 4;
    localparam int          BH   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        hit;
    logic [31:0] rdata;
    logic [4:0]  SW = '0;
    logic [6:0]  gled, gled2, gled3, gled4;

    always #5 clk = ~clk;

    mmio_display_ctrl #(
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_HALF     (BH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .hit      (hit),
        .rdata    (rdata),
        .SW       (SW),
        .gled     (gled),
        .gled2    (gled2),
        .gled3    (gled3),
        .gled4    (gled4)
    );

    typedef enum {K_RDATA, K_HIT, K_SEGS} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state
    logic [15:0] m_disp;
    logic        m_en;
    logic        m_blink;
    logic [4:0]  m_swst;
    logic [4:0]  m_swchg;
    int          cyc;

    // Rising edges since reset release; drives the blink-phase prediction.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Digits as currently visible: registers settled one edge ago, blink phase from that edge.
    function automatic logic [31:0] exp_segs();
        logic dark;
        dark = !m_en || (m_blink && ((((cyc - 1) / BH) % 2) == 1));
        if (dark) return {4'h0, {4{7'h7F}}};
        return {4'h0, seg_of(m_disp[15:12]), seg_of(m_disp[11:8]), seg_of(m_disp[7:4]), seg_of(m_disp[3:0])};
    endfunction

    function automatic logic [31:0] exp_reg(input int off);
        case (off)
            0: return {16'h0, m_disp};
            1: return {30'h0, m_blink, m_en};
            2: return {27'h0, m_swst};
            default: return {27'h0, m_swchg};
        endcase
    endfunction

    // Monitor: compares the oldest expectation against the DUT at each requested negedge.
    always @(negedge clk) begin
        if (chk_req) begin
            exp_t        e;
            logic [31:0] act;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: monitor request with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_RDATA: act = rdata;
                    K_HIT:   act = {31'h0, hit};
                    default: act = {4'h0, gled4, gled3, gled2, gled};
                endcase
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic post(input string name, input kind_e k, input logic [31:0] exp);
        exp_q.push_back('{name, k, exp});
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic check_rd(input string name, input int off);
        memwrite = 1'b0;
        dataadr  = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
        post(name, K_RDATA, exp_reg(off));
    endtask

    task automatic check_segs(input string name);
        post(name, K_SEGS, exp_segs());
    endtask

    // Store; the model follows the register map for addresses inside the window.
    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        dataadr   = adr;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        if (adr[31:4] == BASE[31:4]) begin
            case (adr[3:2])
                2'd0: m_disp = d[15:0];
                2'd1: begin
                    m_en = d[0];
`ifdef MMIO_BLINK_EN
                    m_blink = d[1];
`endif
                end
                2'd3: m_swchg = m_swchg & ~d[4:0];
                default: ;
            endcase
        end
    endtask

    // Held switch change: accepted exactly 2 + DEB edges after it is applied.
    task automatic sw_hold(input logic [4:0] v);
        SW = v;
        step(DEB + 1);
        check_rd("swst_before_accept", 2);
        step(1);
        m_swchg = m_swchg | (v ^ m_swst);
        m_swst  = v;
        check_rd("swst_accepted", 2);
        check_rd("swchg_after_accept", 3);
        step(1);
    endtask

    // Short pulse of length len (< DEB edges) must not be accepted.
    task automatic sw_glitch(input logic [4:0] v, input int len);
        logic [4:0] keep;
        keep = SW;
        SW = v;
        step(len);
        SW = keep;
        step(DEB + 2);
        check_rd("swst_after_glitch", 2);
        check_rd("swchg_after_glitch", 3);
        step(1);
    endtask

    task automatic model_reset();
        m_disp  = '0;
        m_en    = 1'b0;
        m_blink = 1'b0;
        m_swst  = '0;
        m_swchg = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        step(3);
        check_segs("reset_segs");
        reset = 1'b0;
        step(1);
        for (int off = 0; off < 4; off++) check_rd("reset_reg", off);

        // Directed display pattern.
        wr(BASE + 32'h0, 32'h0000_12AF);
        check_rd("disp_readback", 0);
        wr(BASE + 32'h4, 32'h1);
        step(1);
        check_segs("segs_12AF");
        post("seg_pattern_const", K_SEGS, {4'h0, 7'h79, 7'h24, 7'h08, 7'h0E});

        // Switch acceptance latency and glitch rejection.
        step(1);
        sw_hold(5'h05);
        sw_glitch(5'h1A, 2);

        // W1C in the same cycle as a new acceptance: the set wins.
        wr(BASE + 32'hC, 32'h1F);
        check_rd("swchg_cleared", 3);
        step(1);
        sw_hold(5'h04);
        SW = 5'h00;
        step(DEB + 1);
        wr(BASE + 32'hC, 32'h1);
        m_swchg = m_swchg | 5'h04;
        m_swst  = 5'h00;
        check_rd("swchg_conflict", 3);
        post("swchg_conflict_const", K_RDATA, 32'h04);
        check_rd("swst_conflict", 2);
        step(1);

        // Store outside the window.
        wr(32'hFFFF_FEFC, 32'hDEAD_BEEF);
        dataadr = 32'hFFFF_FEFC;
        post("hit_outside", K_HIT, 32'h0);
        post("rdata_outside", K_RDATA, 32'h0);
        dataadr = BASE + 32'h0;
        post("hit_inside", K_HIT, 32'h1);
        check_rd("disp_unchanged", 0);

        // CTRL with blink requested.
        step(1);
        wr(BASE + 32'h4, 32'h3);
        check_rd("ctrl_readback", 1);
`ifdef MMIO_BLINK_EN
        step(1);
        for (int i = 0; i < 9; i++) begin
            check_segs("blink_segs");
            step(1);
        end
`else
        post("ctrl_no_blink", K_RDATA, 32'h1);
`endif

        // Randomized register traffic and switch activity.
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 6);
            step(1);
            case (op)
                0: begin
                    wr(BASE + 32'h0 + 32'($urandom_range(0, 3)), $urandom);
                    check_rd("rand_disp", 0);
                    step(1);
                    check_segs("rand_disp_segs");
                end
                1: begin
                    wr(BASE + 32'h4, $urandom);
                    check_rd("rand_ctrl", 1);
                    step(1);
                    check_segs("rand_ctrl_segs");
                end
                2: check_rd("rand_read", int'($urandom_range(0, 3)));
                3: sw_hold(m_swst ^ 5'($urandom_range(1, 31)));
                4: sw_glitch(m_swst ^ 5'($urandom_range(1, 31)), int'($urandom_range(1, DEB - 1)));
                5: begin
                    wr(BASE + 32'hC, $urandom);
                    check_rd("rand_w1c", 3);
                end
                default: begin
                    logic [31:0] adr;
                    adr = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 64))
                                                       : BASE + 32'h10 + 32'($urandom_range(0, 64));
                    wr(adr, $urandom);
                    dataadr = adr;
                    post("rand_outside_rdata", K_RDATA, 32'h0);
                    for (int off = 0; off < 4; off++) check_rd("rand_outside_regs", off);
                end
            endcase
        end

        // Reset mid-debounce: outputs clear immediately and the pending change is dropped.
        step(1);
        wr(BASE + 32'h4, 32'h1);
        wr(BASE + 32'h0, 32'h0000_8888);
        SW = ~m_swst;
        step(3);
        reset = 1'b1;
        model_reset();
        post("async_reset_segs", K_SEGS, {4'h0, {4{7'h7F}}});
        for (int off = 0; off < 4; off++) check_rd("async_reset_reg", off);
        SW = 5'h00;
        step(1);
        reset = 1'b0;
        step(DEB + 4);
        check_rd("post_reset_swst", 2);
        check_rd("post_reset_swchg", 3);
        check_segs("post_reset_segs");

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d expectations never checked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
